// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall and flush scheduler for the 5-stage MIPS pipeline.
// Detects load-use and ID-branch operand hazards, sequences the multi-cycle
// multiply/divide unit via a busy counter, and counts stall cycles.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UseRt,
    input  logic             Branch,
    input  logic             BrTaken,
    input  logic             Jump,
    input  logic             MdStart,
    input  logic             MdDiv,
    input  logic             MfHiLo,
    input  logic [4:0]       IDEX_Rd,
    input  logic             IDEX_RegWr,
    input  logic             IDEX_MemRd,
    input  logic [4:0]       EXMEM_Rd,
    input  logic             EXMEM_MemRd,
    output logic             PCWr,
    output logic             IFIDWr,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             MdLaunch,
    output logic             MdBusy,
    output logic [CNT_W-1:0] StallCnt
);

    localparam logic [5:0] MUL_CNT = 6'(MUL_LAT);
    localparam logic [5:0] DIV_CNT = 6'(DIV_LAT);

    typedef enum logic {MD_IDLE, MD_BUSY} mdState_t;

    mdState_t         mdState;
    logic [5:0]       mdCnt;
    logic [CNT_W-1:0] stallCnt;
    logic             luHaz;
    logic             brHaz;
    logic             mdHaz;
    logic             stall;

    // True when a producer register feeds a source operand of the ID instruction; $0 never matches.
    function automatic logic regMatch(input logic [4:0] r, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic useRt);
        return (r != 5'd0) && ((r == rs) || (useRt && (r == rt)));
    endfunction

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Hazard detection: all terms are purely combinational on the current cycle.
    always_comb begin
        luHaz = IDEX_MemRd && regMatch(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UseRt);
        brHaz = Branch &&
                ((IDEX_RegWr && regMatch(IDEX_Rd, IFID_Rs, IFID_Rt, IFID_UseRt)) ||
                 (EXMEM_MemRd && regMatch(EXMEM_Rd, IFID_Rs, IFID_Rt, IFID_UseRt)));
        mdHaz = (mdState == MD_BUSY) && (MfHiLo || MdStart);
        stall = luHaz || brHaz || mdHaz;
    end

    // Pipeline control lines; reset holds the front end empty, a stall masks any flush.
    always_comb begin
        PCWr       = 1'b0;
        IFIDWr     = 1'b0;
        IFIDFlush  = 1'b1;
        IDEXBubble = 1'b1;
        MdLaunch   = 1'b0;
        if (rst_n) begin
            PCWr       = !stall;
            IFIDWr     = !stall;
            IDEXBubble = stall;
            IFIDFlush  = !stall && ((Branch && BrTaken) || Jump);
            MdLaunch   = (mdState == MD_IDLE) && MdStart && !stall;
        end
    end

    // MDU busy sequencer and saturating stall-cycle counter; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdState  <= MD_IDLE;
            mdCnt    <= 6'd0;
            stallCnt <= '0;
        end else begin
            case (mdState)
                MD_IDLE: begin
                    if (MdLaunch) begin
                        mdCnt   <= MdDiv ? DIV_CNT : MUL_CNT;
                        mdState <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    mdCnt <= mdCnt - 6'd1;
                    if (mdCnt == 6'd1) begin
                        mdState <= MD_IDLE;
                    end
                end
                default: begin
                    mdState <= MD_IDLE;
                    mdCnt   <= 6'd0;
                end
            endcase
            if (stall) begin
                stallCnt <= satInc(stallCnt);
            end
        end
    end

    assign MdBusy   = (mdState == MD_BUSY);
    assign StallCnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors, directed multi-cycle sequences and random
// stimulus against a cycle-level reference model of the hazard scheduler.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rd = '0, EXMEM_Rd = '0;
    logic IFID_UseRt = 0, Branch = 0, BrTaken = 0, Jump = 0, MdStart = 0, MdDiv = 0, MfHiLo = 0;
    logic IDEX_RegWr = 0, IDEX_MemRd = 0, EXMEM_MemRd = 0;
    logic PCWr, IFIDWr, IFIDFlush, IDEXBubble, MdLaunch, MdBusy;
    logic [CNT_W-1:0] StallCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UseRt(IFID_UseRt),
        .Branch(Branch), .BrTaken(BrTaken), .Jump(Jump),
        .MdStart(MdStart), .MdDiv(MdDiv), .MfHiLo(MfHiLo),
        .IDEX_Rd(IDEX_Rd), .IDEX_RegWr(IDEX_RegWr), .IDEX_MemRd(IDEX_MemRd),
        .EXMEM_Rd(EXMEM_Rd), .EXMEM_MemRd(EXMEM_MemRd),
        .PCWr(PCWr), .IFIDWr(IFIDWr), .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
        .MdLaunch(MdLaunch), .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: cycles of MDU busy remaining and stall cycles seen.
    int busyLeft  = 0;
    int stallSeen = 0;

    // Values sampled from the DUT at the last step, for directed checks.
    logic smpBubble, smpLaunch, smpBusy, smpFlush, smpPcWr;
    int   smpCnt;

    typedef struct {
        logic [4:0] rs, rt;
        logic       useRt, br, brT, jmp;
        logic [4:0] idexRd;
        logic       idexRegWr, idexMemRd;
        logic [4:0] exmemRd;
        logic       exmemMemRd;
        logic       expStall, expFlush;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, what, act, exp);
        end
    endtask

    function automatic bit reads(input int r);
        return (r != 0) && ((r == int'(IFID_Rs)) || (IFID_UseRt && (r == int'(IFID_Rt))));
    endfunction

    function automatic bit modelStall();
        bit lu, bh, mh;
        lu = IDEX_MemRd && reads(int'(IDEX_Rd));
        bh = Branch && ((IDEX_RegWr && reads(int'(IDEX_Rd))) || (EXMEM_MemRd && reads(int'(EXMEM_Rd))));
        mh = (busyLeft > 0) && (MfHiLo || MdStart);
        return lu || bh || mh;
    endfunction

    task automatic clearInputs();
        IFID_Rs = 0; IFID_Rt = 0; IFID_UseRt = 0; Branch = 0; BrTaken = 0; Jump = 0;
        MdStart = 0; MdDiv = 0; MfHiLo = 0; IDEX_Rd = 0; IDEX_RegWr = 0; IDEX_MemRd = 0;
        EXMEM_Rd = 0; EXMEM_MemRd = 0;
    endtask

    // One clock cycle: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic step(input string tag, input bit hasExp = 0, input bit eStall = 0, input bit eFlush = 0);
        bit s, launch, flush;
        @(negedge clk);
        s      = modelStall();
        launch = !s && (busyLeft == 0) && MdStart;
        flush  = !s && ((Branch && BrTaken) || Jump);
        chk(tag, "PCWr", PCWr, !s);
        chk(tag, "IFIDWr", IFIDWr, !s);
        chk(tag, "IDEXBubble", IDEXBubble, s);
        chk(tag, "IFIDFlush", IFIDFlush, flush);
        chk(tag, "MdLaunch", MdLaunch, launch);
        chk(tag, "MdBusy", MdBusy, busyLeft > 0);
        chk(tag, "StallCnt", StallCnt, stallSeen);
        if (hasExp) begin
            chk(tag, "tblStall", IDEXBubble, eStall);
            chk(tag, "tblFlush", IFIDFlush, eFlush);
        end
        smpBubble = IDEXBubble; smpLaunch = MdLaunch; smpBusy = MdBusy;
        smpFlush = IFIDFlush; smpPcWr = PCWr; smpCnt = int'(StallCnt);
        @(posedge clk);
        if (s && stallSeen < CNT_MAX) stallSeen++;
        if (busyLeft > 0) busyLeft--;
        else if (launch) busyLeft = MdDiv ? DIV_LAT : MUL_LAT;
        #1;
    endtask

    // Assert reset now, check the held-empty outputs, release just after the next edge.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        busyLeft = 0;
        stallSeen = 0;
        chk(tag, "rstPCWr", PCWr, 0);
        chk(tag, "rstIFIDWr", IFIDWr, 0);
        chk(tag, "rstFlush", IFIDFlush, 1);
        chk(tag, "rstBubble", IDEXBubble, 1);
        chk(tag, "rstLaunch", MdLaunch, 0);
        chk(tag, "rstBusy", MdBusy, 0);
        chk(tag, "rstCnt", StallCnt, 0);
        clearInputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit done;
        //             rs rt uRt br brT jmp idRd wr  mem exRd exMem  stall flush
        vecs[0] = '{5'd8, 5'd0, 0, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 1, 0};
        vecs[1] = '{5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 5'd0, 0, 0, 0};
        vecs[2] = '{5'd1, 5'd8, 0, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0};
        vecs[3] = '{5'd1, 5'd8, 1, 0, 0, 0, 5'd8, 1, 1, 5'd0, 0, 1, 0};
        vecs[4] = '{5'd5, 5'd0, 0, 0, 0, 0, 5'd5, 1, 0, 5'd0, 0, 0, 0};
        vecs[5] = '{5'd5, 5'd0, 0, 1, 1, 0, 5'd5, 1, 0, 5'd0, 0, 1, 0};
        vecs[6] = '{5'd2, 5'd7, 1, 1, 0, 0, 5'd0, 0, 0, 5'd7, 1, 1, 0};
        vecs[7] = '{5'd5, 5'd6, 1, 1, 1, 0, 5'd9, 1, 0, 5'd10, 1, 0, 1};
        vecs[8] = '{5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1};
        vecs[9] = '{5'd3, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd3, 1, 0, 0};

        #2;
        doReset("init");

        // Combinational hazard table with the MDU idle.
        for (int i = 0; i < 10; i++) begin
            IFID_Rs = vecs[i].rs; IFID_Rt = vecs[i].rt; IFID_UseRt = vecs[i].useRt;
            Branch = vecs[i].br; BrTaken = vecs[i].brT; Jump = vecs[i].jmp;
            IDEX_Rd = vecs[i].idexRd; IDEX_RegWr = vecs[i].idexRegWr; IDEX_MemRd = vecs[i].idexMemRd;
            EXMEM_Rd = vecs[i].exmemRd; EXMEM_MemRd = vecs[i].exmemMemRd;
            step($sformatf("vec%0d", i), 1, vecs[i].expStall, vecs[i].expFlush);
        end

        // Load-use: exactly one stall, counter 0 -> 1.
        doReset("lu");
        IDEX_MemRd = 1; IDEX_RegWr = 1; IDEX_Rd = 8; IFID_Rs = 8;
        step("lu1");
        chk("lu", "stall1", smpBubble, 1);
        IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_Rd = 0; EXMEM_MemRd = 1; EXMEM_Rd = 8;
        step("lu2");
        chk("lu", "stall2", smpBubble, 0);
        chk("lu", "cnt", smpCnt, 1);

        // Load feeding a taken branch: two stalls, then flush.
        doReset("ldbr");
        Branch = 1; BrTaken = 1; IFID_Rs = 5; IDEX_MemRd = 1; IDEX_RegWr = 1; IDEX_Rd = 5;
        step("ldbr1");
        chk("ldbr", "stall1", smpBubble, 1);
        chk("ldbr", "noFlush1", smpFlush, 0);
        IDEX_MemRd = 0; IDEX_RegWr = 0; IDEX_Rd = 0; EXMEM_MemRd = 1; EXMEM_Rd = 5;
        step("ldbr2");
        chk("ldbr", "stall2", smpBubble, 1);
        EXMEM_MemRd = 0; EXMEM_Rd = 0;
        step("ldbr3");
        chk("ldbr", "flush", smpFlush, 1);
        chk("ldbr", "pcwr", smpPcWr, 1);
        chk("ldbr", "cnt", smpCnt, 2);

        // Multiply then mflo: four stalls, proceeds at t+5.
        doReset("mul");
        MdStart = 1; MdDiv = 0;
        step("mul0");
        chk("mul", "launch", smpLaunch, 1);
        MdStart = 0; MfHiLo = 1;
        n = 0; done = 0;
        for (int k = 0; k < 10 && !done; k++) begin
            step("mulw");
            if (smpBubble) n++; else done = 1;
        end
        chk("mul", "done", done, 1);
        chk("mul", "stalls", n, MUL_LAT);
        chk("mul", "cnt", smpCnt, MUL_LAT);

        // Divide then multiply held in ID: launch at t+33, single pulse; counter saturates.
        doReset("div");
        MdStart = 1; MdDiv = 1;
        step("div0");
        chk("div", "launch", smpLaunch, 1);
        MdDiv = 0;
        n = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            step("divw");
            n++;
            if (smpLaunch) done = 1;
        end
        chk("div", "done", done, 1);
        chk("div", "launchAt", n, DIV_LAT + 1);
        MdStart = 0; IFID_Rs = 9;
        step("div2");
        chk("div", "singlePulse", smpLaunch, 0);
        chk("div", "busy", smpBusy, 1);
        chk("div", "indepNoStall", smpBubble, 0);
        chk("div", "sat", smpCnt, CNT_MAX);

        // MdStart together with a load-use hazard: launch deferred one cycle.
        doReset("sim");
        MdStart = 1; IDEX_MemRd = 1; IDEX_Rd = 8; IFID_Rs = 8;
        step("sim1");
        chk("sim", "noLaunch", smpLaunch, 0);
        IDEX_MemRd = 0; IDEX_Rd = 0;
        step("sim2");
        chk("sim", "launch", smpLaunch, 1);
        MdStart = 0;
        step("sim3");

        // Reset in the middle of a divide, then a clean multiply.
        doReset("mid");
        MdStart = 1; MdDiv = 1;
        step("mid0");
        MdStart = 0; MfHiLo = 1;
        for (int k = 0; k < 10; k++) step("midb");
        chk("mid", "busyBefore", smpBusy, 1);
        #2;
        doReset("midRst");
        MdStart = 1; MdDiv = 0;
        step("post0");
        chk("post", "launch", smpLaunch, 1);
        MdStart = 0;
        for (int k = 0; k < MUL_LAT + 2; k++) step("postb");

        // Random stimulus against the model.
        doReset("rnd");
        for (int k = 0; k < 600; k++) begin
            IFID_Rs = 5'($urandom_range(0, 3)); IFID_Rt = 5'($urandom_range(0, 3));
            IDEX_Rd = 5'($urandom_range(0, 3)); EXMEM_Rd = 5'($urandom_range(0, 3));
            IFID_UseRt = 1'($urandom); Branch = 1'($urandom); BrTaken = 1'($urandom);
            Jump = ($urandom_range(0, 7) == 0); MdStart = ($urandom_range(0, 7) == 0);
            MdDiv = ($urandom_range(0, 3) == 0); MfHiLo = ($urandom_range(0, 3) == 0);
            IDEX_RegWr = 1'($urandom); IDEX_MemRd = ($urandom_range(0, 3) == 0);
            EXMEM_MemRd = ($urandom_range(0, 3) == 0);
            step("rnd");
            if (k == 300) doReset("rndRst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
